// File: rtl/module_mult_booth_ctrl_pkg.sv
// Shared types for the radix-2 Booth multiplier: datapath control word and controller states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package booth_pkg;

  // Control word to the datapath; field order is fixed, first field is the MSB.
  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic shift_HQ_LQ_Q_1;
    logic add_sub;
  } control_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EVAL   = 3'd3,
    ST_ADDSUB = 3'd4,
    ST_SHIFT  = 3'd5,
    ST_DONE   = 3'd6
  } booth_state_t;

  localparam control_t CTRL_IDLE = '0;

endpackage : booth_pkg

// File: rtl/module_booth_iter_cnt.sv
// Booth iteration counter: clear, increment, terminal flag when count == N-1.
// Latency: count updates on the clock edge after clr_i/inc_i; last_o is decoded from the register.
// Backpressure: none; holds its value when neither clr_i nor inc_i is set, never wraps.
module module_booth_iter_cnt #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment; saturate at N so the count cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(N))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(N - 1));

endmodule : module_booth_iter_cnt

// File: rtl/module_mult_booth_ctrl.sv
// Sequencing FSM for the radix-2 Booth datapath: loads, N eval/add-sub/shift iterations, done pulse.
// Latency: done in cycle 2+2N+a+1 after the accept edge (a = add/sub iterations); Moore registered outputs.
// Backpressure: start is sampled only in IDLE and never queued; Q_LSB is sampled only in EVAL.
module module_mult_booth_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Q_LSB,
  output control_t   mult_control,
  output logic       busy,
  output logic       done
);

  booth_state_t state_q;
  control_t     ctrl_q;
  logic         busy_q;
  logic         done_q;
  logic         cnt_clr;
  logic         cnt_inc;
  logic         cnt_last;

  // The counter clears on the accept edge and advances once per SHIFT.
  assign cnt_clr = (state_q == ST_IDLE) && start;
  assign cnt_inc = (state_q == ST_SHIFT);

  module_booth_iter_cnt #(
    .N (N)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  // State register plus registered Moore outputs; each output is loaded with the decode of the
  // state being entered, so add_sub doubles as the 1-bit op latched in EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctrl_q  <= CTRL_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ctrl_q <= CTRL_IDLE;
      done_q <= 1'b0;
      busy_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_LOAD_A;
            ctrl_q.load_A <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_LOAD_A: begin
          state_q       <= ST_LOAD_B;
          ctrl_q.load_B <= 1'b1;
        end
        ST_LOAD_B: begin
          state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          if ((Q_LSB == 2'b01) || (Q_LSB == 2'b10)) begin
            state_q         <= ST_ADDSUB;
            ctrl_q.load_add <= 1'b1;
            ctrl_q.add_sub  <= (Q_LSB == 2'b01);
          end else begin
            state_q                <= ST_SHIFT;
            ctrl_q.shift_HQ_LQ_Q_1 <= 1'b1;
          end
        end
        ST_ADDSUB: begin
          state_q                <= ST_SHIFT;
          ctrl_q.shift_HQ_LQ_Q_1 <= 1'b1;
        end
        ST_SHIFT: begin
          if (cnt_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_EVAL;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mult_control = ctrl_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule : module_mult_booth_ctrl

// File: tb/tb_module_mult_booth_ctrl.sv
// Bench for the Booth controller, driving a behavioural radix-2 Booth datapath (N=8).
// Latency: checks done cycle, product Y and the add/sub control trace against hand-computed values.
// Backpressure: exercises start held high, start pulses while busy and reset mid-operation.
module tb_module_mult_booth_ctrl;
  import booth_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] Q_LSB;
  control_t   mult_control;
  logic       busy;
  logic       done;

  logic [7:0] A_in = 8'd0;
  logic [7:0] B_in = 8'd0;
  logic [7:0] M_q, HQ_q, LQ_q;
  logic       Q1_q;
  logic [15:0] Y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  module_mult_booth_ctrl #(.N(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Q_LSB        (Q_LSB),
    .mult_control (mult_control),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural Booth datapath reacting to the control word.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      M_q <= '0; HQ_q <= '0; LQ_q <= '0; Q1_q <= 1'b0;
    end else begin
      if (mult_control.load_A) M_q <= A_in;
      if (mult_control.load_B) begin
        LQ_q <= B_in; HQ_q <= '0; Q1_q <= 1'b0;
      end
      if (mult_control.load_add) HQ_q <= mult_control.add_sub ? (HQ_q + M_q) : (HQ_q - M_q);
      if (mult_control.shift_HQ_LQ_Q_1) {HQ_q, LQ_q, Q1_q} <= {HQ_q[7], HQ_q, LQ_q};
    end
  end

  assign Q_LSB = {LQ_q[0], Q1_q};
  assign Y     = {HQ_q, LQ_q};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Raise start across one edge (the accept edge); returns #1 into cycle 1.
  task automatic start_mult(input logic [7:0] a, input logic [7:0] b);
    A_in = a; B_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Follows an operation from cycle 1 to the done cycle; dcyc = -1 on timeout.
  task automatic track_to_done(input int pulse_at, output int dcyc, output int nadd,
                               output logic [7:0] ops, output int gaps);
    dcyc = 1; nadd = 0; ops = '0; gaps = 0;
    while (done !== 1'b1 && dcyc < 200) begin
      if (pulse_at > 0) start = (dcyc == pulse_at);
      if (busy !== 1'b1) gaps++;
      if (mult_control.load_add === 1'b1) begin
        nadd++;
        ops = {ops[6:0], mult_control.add_sub};
      end
      @(posedge clk); #1;
      dcyc++;
    end
    if (pulse_at > 0) start = 1'b0;
    if (done !== 1'b1) dcyc = -1;
    else if (busy !== 1'b1) gaps++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (mult_control !== CTRL_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ctrl=%b busy=%b done=%b, required 00000/0/0", mult_control, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mult_control !== CTRL_IDLE) begin
      errors++;
      $display("FAIL reset_release: busy=%b ctrl=%b, required 0/00000", busy, mult_control);
    end
    start_mult(8'd11, 8'd14);
    checks++;
    if (mult_control.load_A !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cycle1_load_A: load_A=%b busy=%b, required 1/1", mult_control.load_A, busy);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (mult_control !== CTRL_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b busy=%b done=%b, required 00000/0/0", mult_control, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_directed_vectors();
    logic [7:0]  va   [3] = '{8'd11, 8'd11, 8'hFD};
    logic [7:0]  vb   [3] = '{8'd14, 8'd0, 8'h55};
    logic [15:0] vy   [3] = '{16'd154, 16'd0, 16'hFF01};
    int          vcyc [3] = '{21, 19, 27};
    int          vadd [3] = '{2, 0, 8};
    logic [7:0]  vops [3] = '{8'h01, 8'h00, 8'h55};
    int dcyc, nadd, gaps;
    logic [7:0] ops;
    for (int i = 0; i < 3; i++) begin
      start_mult(va[i], vb[i]);
      track_to_done(0, dcyc, nadd, ops, gaps);
      checks++;
      if (dcyc != vcyc[i]) begin
        errors++;
        $display("FAIL vec%0d_done_cycle: got %0d, required %0d", i, dcyc, vcyc[i]);
      end
      checks++;
      if (Y !== vy[i]) begin
        errors++;
        $display("FAIL vec%0d_product: Y=%h, required %h", i, Y, vy[i]);
      end
      checks++;
      if (nadd != vadd[i] || ops !== vops[i]) begin
        errors++;
        $display("FAIL vec%0d_addsub_trace: count=%0d ops=%b, required %0d/%b", i, nadd, ops, vadd[i], vops[i]);
      end
      checks++;
      if (gaps != 0) begin
        errors++;
        $display("FAIL vec%0d_busy: busy low in %0d cycles, required 0", i, gaps);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_after_done: busy=%b done=%b, required 0/0", i, busy, done);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dcyc, nadd, gaps;
    logic [7:0] ops;
    start_mult(8'd11, 8'd0);
    track_to_done(6, dcyc, nadd, ops, gaps);
    checks++;
    if (dcyc != 19 || Y !== 16'd0) begin
      errors++;
      $display("FAIL busy_pulse_ignored: done cycle %0d Y=%h, required 19/0000", dcyc, Y);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_ignored: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mult_control !== CTRL_IDLE) begin
      errors++;
      $display("FAIL start_not_queued: busy=%b ctrl=%b, required 0/00000", busy, mult_control);
    end
  endtask

  task automatic test_back_to_back();
    int dcyc, nadd, gaps;
    logic [7:0] ops;
    start_mult(8'd11, 8'd14);
    start = 1'b1;
    track_to_done(0, dcyc, nadd, ops, gaps);
    checks++;
    if (dcyc != 21 || Y !== 16'd154) begin
      errors++;
      $display("FAIL b2b_first: done cycle %0d Y=%h, required 21/009a", dcyc, Y);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mult_control !== CTRL_IDLE) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b ctrl=%b, required 0/00000", busy, mult_control);
    end
    @(posedge clk); #1;
    checks++;
    if (mult_control.load_A !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: load_A=%b, required 1", mult_control.load_A);
    end
    track_to_done(0, dcyc, nadd, ops, gaps);
    start = 1'b0;
    checks++;
    if (dcyc != 21 || Y !== 16'd154 || nadd != 2) begin
      errors++;
      $display("FAIL b2b_second: done cycle %0d Y=%h addsub=%0d, required 21/009a/2", dcyc, Y, nadd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_iteration();
    int shifts, guard, dcyc, nadd, gaps;
    bit seen_done;
    logic [7:0] ops;
    shifts = 0; guard = 0; seen_done = 0;
    start_mult(8'd11, 8'd14);
    while (shifts < 4 && guard < 100) begin
      if (mult_control.shift_HQ_LQ_Q_1 === 1'b1) shifts++;
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    checks++;
    if (mult_control.load_add !== 1'b1 || mult_control.add_sub !== 1'b1) begin
      errors++;
      $display("FAIL iter4_add: load_add=%b add_sub=%b, required 1/1", mult_control.load_add, mult_control.add_sub);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (mult_control !== CTRL_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%b busy=%b done=%b, required 00000/0/0", mult_control, busy, done);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy !== 1'b0) seen_done = 1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL mid_reset_quiet: activity seen after reset, required none");
    end
    start_mult(8'd11, 8'd14);
    track_to_done(0, dcyc, nadd, ops, gaps);
    checks++;
    if (dcyc != 21 || Y !== 16'd154) begin
      errors++;
      $display("FAIL after_reset_mult: done cycle %0d Y=%h, required 21/009a", dcyc, Y);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed_vectors();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_iteration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_module_mult_booth_ctrl
